// File: rtl/gpio_seq_pkg.sv
// Shared constants and types for the GPIO pattern sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_seq_pkg;

  // Register offsets, decoded on ADDR[4:0]
  localparam logic [4:0] GSEQ_CTRL = 5'h00;
  localparam logic [4:0] GSEQ_STAT = 5'h04;
  localparam logic [4:0] GSEQ_LEN  = 5'h08;
  localparam logic [4:0] GSEQ_IDX  = 5'h0C;
  localparam logic [4:0] GSEQ_DATA = 5'h10;
  localparam logic [4:0] GSEQ_CUR  = 5'h14;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_STOP   = 1;
  localparam int CTRL_LOOP   = 2;
  localparam int CTRL_IRQ_EN = 3;

  // STAT bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IDX_LSB = 8;

  // Table entry layout
  localparam int ENTRY_VAL_LSB = 0;
  localparam int ENTRY_DLY_LSB = 16;
  localparam int ENTRY_DLY_W   = 16;

  // Output data register of the GPIO block this sequencer drives
  localparam logic [31:0] GPIO_GPO = 32'h0000_0004;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT,
    NEXT
  } seq_state_t;

endpackage

// File: rtl/gpio_seq_ram.sv
// Pattern table: single write port, asynchronous read port.
// Latency: write lands on the next edge; read is combinational.
// Backpressure: none.
module gpio_seq_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Table write; contents intentionally carry no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gpio_seq.sv
// GPIO pattern sequencer: plays {value, delay} table entries onto a GPIO output register.
// Latency: start write in cycle N gives first M_WE in N+1; pulses spaced delay+2 cycles.
// Backpressure: none; slave accepts every access, master writes are fire-and-forget.
module gpio_seq
  import gpio_seq_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          GPIO_W   = 8,
  parameter int          DEPTH    = 16,
  parameter logic [31:0] TGT_ADDR = GPIO_GPO
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              WE,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD,
  output logic              IRQ,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic              M_WE,
  output logic [DATA_W-1:0] M_WD
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  seq_state_t        state_q, state_d;
  logic [IW-1:0]     index_q, index_d;
  logic [IW-1:0]     idx_q;
  logic [LW-1:0]     len_q, len_clamp;
  logic [15:0]       cnt_q, cnt_d;
  logic              loop_q, irq_en_q, irq_en_d, done_q, done_d, done_set, irq_q;
  logic [DATA_W-1:0] entry;
  logic [15:0]       dly;
  logic [4:0]        reg_sel;
  logic              wr_ctrl, wr_stat, wr_len, wr_idx, wr_data;
  logic              start, stop, busy, last, tbl_we;
  logic              unused_addr;

  assign reg_sel = ADDR[4:0];
  assign wr_ctrl = WE && (reg_sel == GSEQ_CTRL);
  assign wr_stat = WE && (reg_sel == GSEQ_STAT);
  assign wr_len  = WE && (reg_sel == GSEQ_LEN);
  assign wr_idx  = WE && (reg_sel == GSEQ_IDX);
  assign wr_data = WE && (reg_sel == GSEQ_DATA);
  assign start   = wr_ctrl && WD[CTRL_START];
  assign stop    = wr_ctrl && WD[CTRL_STOP];
  assign busy    = (state_q != IDLE);
  assign tbl_we  = RST && wr_data && !busy;
  assign unused_addr = ^ADDR[ADDR_W-1:5];

  assign len_clamp = (WD > DATA_W'(DEPTH)) ? LW'(DEPTH) : WD[LW-1:0];
  assign dly       = entry[ENTRY_DLY_LSB +: ENTRY_DLY_W];
  assign last      = ({1'b0, index_q} == (len_q - LW'(1)));
  assign irq_en_d  = wr_ctrl ? WD[CTRL_IRQ_EN] : irq_en_q;
  // Completion set beats a simultaneous write-1-to-clear.
  assign done_d    = done_set ? 1'b1 : ((wr_stat && WD[STAT_DONE]) ? 1'b0 : done_q);

  // The playing index also addresses the table, so CUR reads and WRITE share one port.
  gpio_seq_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (CLK),
    .we    (tbl_we),
    .waddr (idx_q),
    .wdata (WD),
    .raddr (index_q),
    .rdata (entry)
  );

  // Next-state: walk the table, insert the programmed hold, stop overrides everything.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    cnt_d    = cnt_q;
    done_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (len_q != '0)) begin
          state_d = WRITE;
          index_d = '0;
        end
      end
      WRITE: begin
        cnt_d   = dly;
        state_d = (dly == 16'd0) ? NEXT : WAIT;
      end
      WAIT: begin
        if (cnt_q == 16'd1) state_d = NEXT;
        else                cnt_d   = cnt_q - 16'd1;
      end
      NEXT: begin
        if (last) begin
          if (loop_q) begin
            index_d = '0;
            state_d = WRITE;
          end else begin
            done_set = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          index_d = index_q + IW'(1);
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d  = IDLE;
      index_d  = index_q;
      done_set = 1'b0;
    end
  end

  // State and control registers; configuration writes are dropped while playing.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      index_q  <= '0;
      cnt_q    <= '0;
      loop_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      len_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      cnt_q    <= cnt_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      irq_q    <= done_d & irq_en_d;
      if (wr_ctrl) loop_q <= WD[CTRL_LOOP];
      if (wr_len && !busy) len_q <= len_clamp;
      if (wr_idx && !busy)  idx_q <= WD[IW-1:0];
      else if (tbl_we)      idx_q <= idx_q + IW'(1);
    end
  end

  assign IRQ    = irq_q;
  assign M_WE   = (state_q == WRITE);
  assign M_ADDR = M_WE ? ADDR_W'(TGT_ADDR) : '0;
  assign M_WD   = M_WE ? DATA_W'(entry[ENTRY_VAL_LSB +: GPIO_W]) : '0;

  // Slave read mux; CTRL and unmapped offsets read as zero.
  always_comb begin
    RD = '0;
    case (reg_sel)
      GSEQ_STAT: begin
        RD[STAT_BUSY]           = busy;
        RD[STAT_DONE]           = done_q;
        RD[STAT_IDX_LSB +: 8]   = 8'(index_q);
      end
      GSEQ_LEN: RD = DATA_W'(len_q);
      GSEQ_IDX: RD = DATA_W'(idx_q);
      GSEQ_CUR: RD = entry;
      default:  RD = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_seq.sv
// Bench for gpio_seq: schedule-based reference model plus directed literal checks.
// Latency: model predicts every M_WE slot from table delays and the start cycle.
// Backpressure: n/a.
module tb_gpio_seq;
  import gpio_seq_pkg::*;

  localparam int          DEPTH = 16;
  localparam int          MAXC  = 2048;
  localparam logic [31:0] TGT   = 32'h0000_0040;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WE  = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] WD   = '0;
  logic [31:0] RD, M_ADDR, M_WD;
  logic        IRQ, M_WE;

  always #5 CLK = ~CLK;

  gpio_seq #(
    .ADDR_W(32), .DATA_W(32), .GPIO_W(8), .DEPTH(DEPTH), .TGT_ADDR(TGT)
  ) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .WE(WE), .WD(WD), .RD(RD), .IRQ(IRQ),
    .M_ADDR(M_ADDR), .M_WE(M_WE), .M_WD(M_WD)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: per-cycle expectation tables built when a start is accepted
  logic [31:0] tbl [DEPTH];
  bit          exp_we   [MAXC];
  bit [7:0]    exp_wd   [MAXC];
  bit          exp_busy [MAXC];
  bit          exp_dset [MAXC];
  int          exp_idx  [MAXC];
  bit          m_loop, m_irq_en, m_done, m_irq;
  int          m_len, m_idx;

  int       pulse_cyc [$];
  bit [7:0] pulse_wd  [$];

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endfunction

  // Forget everything planned after cycle c; index holds idxv from then on.
  function automatic void cancel(input int c, input int idxv);
    for (int i = c + 1; i < MAXC; i++) begin
      exp_we[i] = 1'b0; exp_busy[i] = 1'b0; exp_dset[i] = 1'b0; exp_idx[i] = idxv;
    end
  endfunction

  // Lay out the write slots: each entry owns delay+2 cycles starting at its write.
  function automatic void schedule(input int c);
    int t, k, d;
    cancel(c, 0);
    t = c + 1;
    k = 0;
    while (t < MAXC) begin
      d = int'(tbl[k][31:16]);
      exp_we[t] = 1'b1;
      exp_wd[t] = tbl[k][7:0];
      for (int i = t; i < t + d + 2 && i < MAXC; i++) begin
        exp_busy[i] = 1'b1; exp_idx[i] = k;
      end
      t = t + d + 2;
      if (k == m_len - 1) begin
        if (!m_loop) begin
          if (t < MAXC) exp_dset[t] = 1'b1;
          for (int i = t; i < MAXC; i++) exp_idx[i] = k;
          break;
        end
        k = 0;
      end else begin
        k++;
      end
    end
  endfunction

  // Model register file: applies the bus access of the cycle that is ending.
  always @(posedge CLK) begin : model_p
    bit st, sp, clr, nd;
    st = 1'b0; sp = 1'b0; clr = 1'b0;
    if (!RST) begin
      m_loop = 1'b0; m_irq_en = 1'b0; m_done = 1'b0; m_irq = 1'b0; m_len = 0; m_idx = 0;
      cancel(cyc, 0);
    end else begin
      if (WE) begin
        case (ADDR[4:0])
          GSEQ_CTRL: begin
            st = WD[0]; sp = WD[1]; m_loop = WD[2]; m_irq_en = WD[3];
          end
          GSEQ_STAT: clr = WD[1];
          GSEQ_LEN:  if (!exp_busy[cyc]) m_len = (WD > 32'(DEPTH)) ? DEPTH : int'(WD);
          GSEQ_IDX:  if (!exp_busy[cyc]) m_idx = int'(WD[3:0]);
          GSEQ_DATA: if (!exp_busy[cyc]) begin
            tbl[m_idx] = WD;
            m_idx = (m_idx + 1) % DEPTH;
          end
          default: ;
        endcase
      end
      if (sp)                                      cancel(cyc, exp_idx[cyc]);
      else if (st && !exp_busy[cyc] && m_len != 0) schedule(cyc);
      nd = exp_dset[cyc + 1] | (m_done & !clr);
      m_done = nd;
      m_irq  = nd & m_irq_en;
    end
    cyc = cyc + 1;
  end

  // Compare master port and IRQ against the model every cycle.
  always @(negedge CLK) begin
    if (cyc >= 1 && cyc < MAXC) begin
      check("m_we",   {31'b0, M_WE}, {31'b0, exp_we[cyc]});
      check("m_addr", M_ADDR, exp_we[cyc] ? TGT : 32'h0);
      check("m_wd",   M_WD,   exp_we[cyc] ? {24'h0, exp_wd[cyc]} : 32'h0);
      check("irq",    {31'b0, IRQ}, {31'b0, m_irq});
      if (M_WE === 1'b1) begin
        pulse_cyc.push_back(cyc);
        pulse_wd.push_back(M_WD[7:0]);
      end
    end
  end

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    ADDR = {27'b0, a}; WD = d; WE = 1'b1;
    @(posedge CLK); #1;
    WE = 1'b0; ADDR = '0; WD = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] e);
    ADDR = {27'b0, a};
    @(negedge CLK);
    check(nm, RD, e);
    @(posedge CLK); #1;
    ADDR = '0;
  endtask

  // STAT read checked against the model; raw value returned for literal pins.
  task automatic rd_stat(input string nm, output logic [31:0] v);
    ADDR = {27'b0, GSEQ_STAT};
    @(negedge CLK);
    v = RD;
    check(nm, RD, {16'h0, 8'(exp_idx[cyc]), 6'b0, m_done, exp_busy[cyc]});
    @(posedge CLK); #1;
    ADDR = '0;
  endtask

  initial begin
    int n, late;
    logic [31:0] v;

    // Reset held two cycles with bus activity
    @(posedge CLK); #1;
    ADDR = '0; WD = 32'h9; WE = 1'b1;
    @(posedge CLK); #1;
    WE = 1'b0;
    @(negedge CLK);
    check("rst_mwe", {31'b0, M_WE}, 32'h0);
    check("rst_irq", {31'b0, IRQ}, 32'h0);
    check("rst_maddr", M_ADDR, 32'h0);
    check("rst_mwd", M_WD, 32'h0);
    @(posedge CLK); #1;
    rd_chk("rst_stat", GSEQ_STAT, 32'h0);
    rd_chk("rst_len", GSEQ_LEN, 32'h0);
    RST = 1'b1;
    idle(1);

    // One-shot with IRQ
    bus_wr(GSEQ_IDX, 32'h0);
    bus_wr(GSEQ_DATA, 32'h0000_0001);
    bus_wr(GSEQ_DATA, 32'h0003_0002);
    bus_wr(GSEQ_DATA, 32'h0001_00FF);
    bus_wr(GSEQ_LEN, 32'd3);
    pulse_cyc.delete(); pulse_wd.delete();
    n = cyc;
    bus_wr(GSEQ_CTRL, 32'h9);
    idle(15);
    check("os_cnt", 32'(pulse_cyc.size()), 32'd3);
    check("os_t0", 32'(pulse_cyc[0]), 32'(n + 1));
    check("os_t1", 32'(pulse_cyc[1]), 32'(n + 3));
    check("os_t2", 32'(pulse_cyc[2]), 32'(n + 8));
    check("os_wd0", {24'h0, pulse_wd[0]}, 32'h01);
    check("os_wd1", {24'h0, pulse_wd[1]}, 32'h02);
    check("os_wd2", {24'h0, pulse_wd[2]}, 32'hFF);
    rd_stat("os_stat", v);
    check("os_stat_lit", v, 32'h0000_0202);
    check("os_irq_lit", {31'b0, IRQ}, 32'h1);
    bus_wr(GSEQ_STAT, 32'h2);
    @(negedge CLK);
    check("os_irq_clr", {31'b0, IRQ}, 32'h0);
    @(posedge CLK); #1;
    rd_chk("os_stat_clr", GSEQ_STAT, 32'h0000_0200);

    // Loop mode, then stop
    bus_wr(GSEQ_IDX, 32'h0);
    bus_wr(GSEQ_DATA, 32'h0000_00A5);
    bus_wr(GSEQ_DATA, 32'h0000_005A);
    bus_wr(GSEQ_LEN, 32'd2);
    pulse_cyc.delete(); pulse_wd.delete();
    n = cyc;
    bus_wr(GSEQ_CTRL, 32'h5);
    idle(40);
    check("lp_cnt", 32'(pulse_cyc.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      check("lp_t", 32'(pulse_cyc[i]), 32'(n + 1 + 2 * i));
      check("lp_wd", {24'h0, pulse_wd[i]}, (i % 2 == 1) ? 32'h5A : 32'hA5);
    end
    pulse_cyc.delete(); pulse_wd.delete();
    n = cyc;
    bus_wr(GSEQ_CTRL, 32'h2);
    idle(6);
    late = 0;
    foreach (pulse_cyc[i]) if (pulse_cyc[i] > n) late++;
    check("stop_quiet", 32'(late), 32'd0);
    rd_stat("stop_stat", v);
    check("stop_busy_done", {30'b0, v[1:0]}, 32'h0);

    // Boundaries
    bus_wr(GSEQ_LEN, 32'd0);
    bus_wr(GSEQ_CTRL, 32'h1);
    rd_stat("len0_stat", v);
    check("len0_busy", {31'b0, v[0]}, 32'h0);
    bus_wr(GSEQ_LEN, 32'd100);
    rd_chk("len_clamp", GSEQ_LEN, 32'd16);
    bus_wr(GSEQ_IDX, 32'd15);
    bus_wr(GSEQ_DATA, 32'h0000_0099);
    rd_chk("idx_wrap", GSEQ_IDX, 32'd0);
    rd_chk("ctrl_rd0", GSEQ_CTRL, 32'h0);
    rd_chk("unmapped_rd0", 5'h18, 32'h0);

    // Busy protection
    bus_wr(GSEQ_IDX, 32'h0);
    bus_wr(GSEQ_DATA, 32'h0002_0011);
    bus_wr(GSEQ_DATA, 32'h0000_0022);
    bus_wr(GSEQ_LEN, 32'd2);
    pulse_cyc.delete(); pulse_wd.delete();
    n = cyc;
    bus_wr(GSEQ_CTRL, 32'h1);
    bus_wr(GSEQ_DATA, 32'h0000_0077);
    bus_wr(GSEQ_LEN, 32'd1);
    bus_wr(GSEQ_CTRL, 32'h1);
    bus_wr(GSEQ_IDX, 32'd5);
    idle(10);
    check("bp_cnt", 32'(pulse_cyc.size()), 32'd2);
    check("bp_t0", 32'(pulse_cyc[0]), 32'(n + 1));
    check("bp_t1", 32'(pulse_cyc[1]), 32'(n + 5));
    check("bp_wd0", {24'h0, pulse_wd[0]}, 32'h11);
    check("bp_wd1", {24'h0, pulse_wd[1]}, 32'h22);
    rd_chk("bp_len", GSEQ_LEN, 32'd2);
    rd_chk("bp_idx", GSEQ_IDX, 32'd2);
    rd_chk("bp_cur", GSEQ_CUR, 32'h0000_0022);

    // Reset in the middle of a long hold
    bus_wr(GSEQ_IDX, 32'h0);
    bus_wr(GSEQ_DATA, 32'h000A_0033);
    bus_wr(GSEQ_LEN, 32'd1);
    bus_wr(GSEQ_CTRL, 32'h1);
    idle(3);
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    pulse_cyc.delete(); pulse_wd.delete();
    idle(15);
    check("rst_mid_quiet", 32'(pulse_cyc.size()), 32'd0);
    rd_stat("rst_mid_stat", v);
    check("rst_mid_stat_lit", v, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
